// File: rtl/la_clkgate_ctrl_pkg.sv
// la_clkgate_ctrl_pkg
//   Shared definitions for the clock-gate enable controller: the FSM state
//   encoding and the width of the post-wake settle counter. Imported by the
//   controller RTL and by its testbench so both agree on the encoding.
package la_clkgate_ctrl_pkg;

  // RUN  : clock running, idle counter active
  // OFF  : clock gated (en low)
  // WAKE : en raised again, waiting for the gated clock to settle
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_t;

  // Settle counter width; WAKE_CYCLES is limited to 1..15.
  localparam int SETTLEW = 4;

endpackage

// File: rtl/la_clkgate_ctrl.sv
// la_clkgate_ctrl
//   Idle-detect controller producing the enable for a latch-based integrated
//   clock gate. Runs on the free-running clock. After idle_limit consecutive
//   idle cycles it drops en; activity or a four-phase wake request raises en
//   again, and the request is acknowledged once the gated clock has settled.
//
// Ports
//   clk        in   free-running clock, rising-edge state updates
//   nreset     in   asynchronous active-low reset
//   busy       in   activity level from the gated domain
//   force_on   in   keeps the clock running while high
//   idle_limit in   [IDLEW] idle cycles before gating, 0 disables gating
//   req        in   four-phase wake request
//   ack        out  four-phase acknowledge (registered)
//   en         out  ICG latch d input (registered)
//   gated      out  high while in OFF (registered)
//   wakes      out  [CNTW] saturating count of OFF->WAKE transitions
//   wakes_clr  in   synchronous clear of wakes, wins over an increment
module la_clkgate_ctrl
  import la_clkgate_ctrl_pkg::*;
#(
  parameter int IDLEW       = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNTW        = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             busy,
  input  logic             force_on,
  input  logic [IDLEW-1:0] idle_limit,
  input  logic             req,
  output logic             ack,
  output logic             en,
  output logic             gated,
  output logic [CNTW-1:0]  wakes,
  input  logic             wakes_clr
);

  localparam logic [SETTLEW-1:0] SETTLE_LAST = SETTLEW'(WAKE_CYCLES - 1);

  state_t             state_reg;
  logic [IDLEW-1:0]   idle_cnt_reg;
  logic [SETTLEW-1:0] settle_cnt_reg;
  logic               en_reg;
  logic               gated_reg;
  logic               ack_reg;
  logic [CNTW-1:0]    wakes_reg;

  logic               act;
  logic [IDLEW:0]     idle_cnt_inc;
  logic               going_off;
  logic               wake_event;

  // A limit of zero is treated as permanent activity, which both disables
  // gating in RUN and wakes the block from OFF.
  assign act = busy | force_on | req | (idle_limit == '0);

  // One extra bit so the >= compare stays exact at the top of the range;
  // gating therefore happens no later than count 2^IDLEW-1 and the stored
  // counter never wraps.
  assign idle_cnt_inc = {1'b0, idle_cnt_reg} + {{IDLEW{1'b0}}, 1'b1};
  assign going_off    = (state_reg == ST_RUN) && !act &&
                        (idle_cnt_inc >= {1'b0, idle_limit});
  assign wake_event   = (state_reg == ST_OFF) && act;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg      <= ST_RUN;
      idle_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      en_reg         <= 1'b1;
      gated_reg      <= 1'b0;
      ack_reg        <= 1'b0;
      wakes_reg      <= '0;
    end else begin
      // req keeps act high, so a high ack implies RUN cannot gate until
      // req is withdrawn.
      ack_reg <= req && (state_reg == ST_RUN) && !going_off;

      case (state_reg)
        ST_RUN: begin
          if (act) begin
            idle_cnt_reg <= '0;
          end else if (going_off) begin
            state_reg    <= ST_OFF;
            en_reg       <= 1'b0;
            gated_reg    <= 1'b1;
            idle_cnt_reg <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_inc[IDLEW-1:0];
          end
        end
        ST_OFF: begin
          if (act) begin
            state_reg      <= ST_WAKE;
            en_reg         <= 1'b1;
            gated_reg      <= 1'b0;
            settle_cnt_reg <= '0;
          end
        end
        ST_WAKE: begin
          // Inputs are ignored here; RUN is reached WAKE_CYCLES edges
          // after the waking edge.
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg <= ST_RUN;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_RUN;
          en_reg    <= 1'b1;
          gated_reg <= 1'b0;
        end
      endcase

      if (wakes_clr) begin
        wakes_reg <= '0;
      end else if (wake_event && !(&wakes_reg)) begin
        wakes_reg <= wakes_reg + 1'b1;
      end
    end
  end

  assign en    = en_reg;
  assign gated = gated_reg;
  assign ack   = ack_reg;
  assign wakes = wakes_reg;

endmodule

// File: tb/tb_la_clkgate_ctrl.sv
// tb_la_clkgate_ctrl
//   Directed bench for la_clkgate_ctrl (IDLEW=8, WAKE_CYCLES=2, CNTW=2).
//   A per-cycle vector table covers gating, waking, the handshake, limit
//   changes, saturation and clear; hand-written loops cover the long
//   no-gating runs and an asynchronous reset taken in the middle of WAKE.
module tb_la_clkgate_ctrl;
  import la_clkgate_ctrl_pkg::*;

  localparam int IDLEW = 8;
  localparam int CNTW  = 2;

  logic             clk = 1'b0;
  logic             nreset;
  logic             busy;
  logic             force_on;
  logic [IDLEW-1:0] idle_limit;
  logic             req;
  logic             ack;
  logic             en;
  logic             gated;
  logic [CNTW-1:0]  wakes;
  logic             wakes_clr;

  la_clkgate_ctrl #(
    .IDLEW(IDLEW),
    .WAKE_CYCLES(2),
    .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .busy(busy),
    .force_on(force_on),
    .idle_limit(idle_limit),
    .req(req),
    .ack(ack),
    .en(en),
    .gated(gated),
    .wakes(wakes),
    .wakes_clr(wakes_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       busy;
    logic       force_on;
    logic       req;
    logic [7:0] limit;
    logic       clr;
    logic       exp_en;
    logic       exp_gated;
    logic       exp_ack;
    logic [1:0] exp_wakes;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  task automatic add(input logic b, input logic f, input logic r,
                     input logic [7:0] lim, input logic c,
                     input logic e, input logic g, input logic a,
                     input logic [1:0] w);
    vec_t v;
    v.busy = b; v.force_on = f; v.req = r; v.limit = lim; v.clr = c;
    v.exp_en = e; v.exp_gated = g; v.exp_ack = a; v.exp_wakes = w;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, want);
  endtask

  task automatic check_all(input string tag, input int idx, input logic e,
                           input logic g, input logic a, input logic [1:0] w);
    check({tag, ".en"},    idx, 32'(en),    32'(e));
    check({tag, ".gated"}, idx, 32'(gated), 32'(g));
    check({tag, ".ack"},   idx, 32'(ack),   32'(a));
    check({tag, ".wakes"}, idx, 32'(wakes), 32'(w));
  endtask

  // Drive inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic b, input logic f, input logic r,
                      input logic [7:0] lim, input logic c);
    @(negedge clk);
    busy = b; force_on = f; req = r; idle_limit = lim; wakes_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset = 1'b0; busy = 1'b0; force_on = 1'b0; req = 1'b0;
    idle_limit = 8'd4; wakes_clr = 1'b0;

    // Reset held for three edges with gating conditions present.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all("reset", i, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    @(negedge clk);
    nreset = 1'b1;

    //   busy f req lim clr | en g ack wakes
    add(0,0,0,4,0, 1,0,0,0);  // 1  idle 1
    add(0,0,0,4,0, 1,0,0,0);  // 2  idle 2
    add(1,0,0,4,0, 1,0,0,0);  // 3  busy restarts count
    add(0,0,0,4,0, 1,0,0,0);  // 4
    add(0,0,0,4,0, 1,0,0,0);  // 5
    add(0,0,0,4,0, 1,0,0,0);  // 6
    add(0,0,0,4,0, 0,1,0,0);  // 7  4th idle edge gates
    add(0,0,0,4,0, 0,1,0,0);  // 8  stays OFF
    add(1,0,0,4,0, 1,0,0,1);  // 9  wake by busy (t0)
    add(0,0,0,4,0, 1,0,0,1);  // 10 WAKE
    add(0,0,0,4,0, 1,0,0,1);  // 11 RUN at t0+2
    add(0,0,0,4,0, 1,0,0,1);  // 12
    add(0,0,0,4,0, 1,0,0,1);  // 13
    add(0,0,0,4,0, 1,0,0,1);  // 14
    add(0,0,0,4,0, 0,1,0,1);  // 15 gated again
    add(0,0,1,4,0, 1,0,0,2);  // 16 wake by req (t0)
    add(0,0,1,4,0, 1,0,0,2);  // 17
    add(0,0,1,4,0, 1,0,0,2);  // 18 RUN entered
    add(0,0,1,4,0, 1,0,1,2);  // 19 ack at t0+3
    add(0,0,1,4,0, 1,0,1,2);  // 20
    add(0,0,0,4,0, 1,0,0,2);  // 21 req drop, ack falls
    add(0,0,0,1,0, 0,1,0,2);  // 22 limit lowered below count
    add(0,0,0,0,0, 1,0,0,3);  // 23 limit 0 while OFF wakes
    add(0,0,0,0,0, 1,0,0,3);  // 24
    add(0,0,0,0,0, 1,0,0,3);  // 25 RUN
    add(0,0,0,1,0, 0,1,0,3);  // 26
    add(1,0,0,1,0, 1,0,0,3);  // 27 wakes saturates
    add(0,0,0,1,0, 1,0,0,3);  // 28 idle ignored in WAKE
    add(0,0,0,1,0, 1,0,0,3);  // 29 RUN
    add(0,0,0,1,0, 0,1,0,3);  // 30
    add(1,0,0,1,1, 1,0,0,0);  // 31 clear wins over increment
    add(0,0,0,1,0, 1,0,0,0);  // 32
    add(0,0,0,1,0, 1,0,0,0);  // 33 RUN
    add(0,1,0,1,0, 1,0,0,0);  // 34 force_on holds RUN
    add(0,1,0,1,0, 1,0,0,0);  // 35
    add(0,0,0,1,0, 0,1,0,0);  // 36
    add(0,1,0,1,0, 1,0,0,1);  // 37 force_on wakes
    add(0,0,0,4,0, 1,0,0,1);  // 38
    add(0,0,0,4,0, 1,0,0,1);  // 39 RUN

    foreach (vecs[i]) begin
      step(vecs[i].busy, vecs[i].force_on, vecs[i].req, vecs[i].limit, vecs[i].clr);
      check_all("vec", i + 1, vecs[i].exp_en, vecs[i].exp_gated,
                vecs[i].exp_ack, vecs[i].exp_wakes);
    end

    // idle_limit=0 disables gating.
    for (int i = 0; i < 1000; i++) begin
      step(0, 0, 0, 8'd0, 0);
      check("lim0.en", i, 32'(en), 32'd1);
    end
    // force_on keeps the clock running.
    for (int i = 0; i < 1000; i++) begin
      step(0, 1, 0, 8'd4, 0);
      check("force.en", i, 32'(en), 32'd1);
    end
    // Held request: ack high, clock never gated.
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 1, 8'd4, 0);
      check("reqhold.en", i, 32'(en), 32'd1);
      check("reqhold.ack", i, 32'(ack), 32'd1);
    end
    step(0, 0, 0, 8'd4, 0);
    check_all("reqdrop", 0, 1'b1, 1'b0, 1'b0, 2'd1);

    // Reach WAKE, then reset asynchronously in the middle of the cycle.
    step(0, 0, 0, 8'd1, 0);
    check_all("pre_off", 0, 1'b0, 1'b1, 1'b0, 2'd1);
    step(1, 0, 0, 8'd1, 0);
    check_all("pre_wake", 0, 1'b1, 1'b0, 1'b0, 2'd2);
    #1 nreset = 1'b0;
    #1;
    check_all("async_rst", 0, 1'b1, 1'b0, 1'b0, 2'd0);
    check("async_rst.state", 0, 32'(dut.state_reg), 32'(ST_RUN));
    @(negedge clk);
    nreset = 1'b1;
    // From RUN, a single idle edge with limit 1 gates immediately.
    step(0, 0, 0, 8'd1, 0);
    check_all("post_rst", 0, 1'b0, 1'b1, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
